chess_clock_ctrl: RTL and testbench
===================================

Name: chess_clock_ctrl

Overview:
Synchronous, parametrised control and time-keeping core for the chess timer. It generalises the earlier two-state enable/set controller into a clocked FSM for NUM_PLAYERS players. The block holds per-player remaining time, switches the active player on each move, applies a Fischer increment, supports pause and time setting, and detects flag fall. It sits between the debounced button inputs and the display/BCD conversion logic, and is driven by an external 1 Hz tick pulse.

Parameters:
NUM_PLAYERS, 2, number of players/clocks (2..8)
TIME_W, 12, width of each player's seconds counter
DEFAULT_TIME, 300, seconds loaded into every player on reset and on clear
INCREMENT, 0, seconds added to the mover's time on each move (Fischer)
PW (localparam), max(1, clog2(NUM_PLAYERS)), width of player index

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
tick  input  1  one-clk-wide pulse, once per second
start_pause  input  1  debounced level button; rising edge toggles run/pause or starts the game
move  input  1  debounced level button; rising edge ends the active player's move
set_mode  input  1  level; high requests SET state
set_load  input  1  debounced level; rising edge writes set_value into player set_player
set_player  input  PW  target player for set_load
set_value  input  TIME_W  seconds value to load
clear  input  1  synchronous new-game pulse/level
time_flat  output  NUM_PLAYERS*TIME_W  remaining seconds; player i at bits [i*TIME_W +: TIME_W]
active_player  output  PW  player whose clock runs
running  output  1  high in RUN
setting  output  1  high in SET
flag  output  1  high in FLAGGED
flag_player  output  PW  player whose time expired

Behaviour:
- All outputs are registered. The async reset drives: state=IDLE; all times=DEFAULT_TIME; active_player=0; running=0; setting=0; flag=0; flag_player=0.
- start_pause, move and set_load are edge-detected internally with one register stage. Action is taken in the cycle after the input's rising edge is sampled. tick is used as-is.
- clear, in any state: next cycle state=IDLE, times=DEFAULT_TIME, active_player=0, flag=0. clear has priority over every other input.
- IDLE:
  - set_mode=1 -> SET.
  - start_pause edge -> RUN with active_player=0.
  - tick and move are ignored.
- SET:
  - setting=1.
  - set_load edge writes set_value to time[set_player]. A set_player >= NUM_PLAYERS is ignored.
  - set_mode=0 -> IDLE.
  - start_pause, tick and move are ignored.
- RUN:
  - running=1.
  - tick: time[active] decrements by 1.
  - If time[active] is 0, or becomes 0 through this decrement, -> FLAGGED next cycle, flag=1, flag_player=active. This check holds even if the player entered RUN with time 0.
  - move edge: time[active] += INCREMENT, saturating at 2^TIME_W-1; active_player=(active+1) mod NUM_PLAYERS.
  - start_pause edge -> PAUSE.
  - set_mode is ignored.
- PAUSE:
  - running=0 and times frozen; tick and move are ignored.
  - start_pause edge -> RUN with the same active_player.
  - set_mode is ignored; only clear leaves PAUSE for IDLE.
- FLAGGED:
  - flag=1 and all times frozen.
  - Only clear or reset exits.
- Simultaneous events in RUN, same cycle:
  - The tick decrement is applied first.
  - If the decrement flags, the move and start_pause in that cycle are discarded.
  - Otherwise the move (increment on the decremented value, then switch player) is applied, then the start_pause transition.
- Wrap and range rules:
  - Time never underflows; it stops at 0.
  - The increment saturates.
  - active_player wraps from NUM_PLAYERS-1 to 0.
- Reset mid-operation returns every register to its reset value immediately, regardless of state.

Test Plan:
- Reset, then start_pause edge, then 3 ticks -> running=1, active_player=0, time0=297, time1=300.
- With INCREMENT=2: RUN, 5 ticks, move edge -> time0=297, active_player=1. Then 1 tick -> time1=299.
- SET: set_mode=1, set_load with set_player=1, set_value=2; set_mode=0; start; move; 2 ticks -> flag=1, flag_player=1, running=0, time1=0. Further ticks and moves leave all values unchanged.
- RUN, start_pause edge, then 10 ticks -> PAUSE, times unchanged. A second start_pause edge resumes with the same active_player.
- Same-cycle tick and move edge with time[active]=1 -> FLAGGED, flag_player=active, active_player unchanged, no increment applied.
- NUM_PLAYERS=3: three move edges cycle active_player 0->1->2->0. Assert reset mid-RUN -> all outputs at reset values. Pulse clear in FLAGGED -> IDLE with DEFAULT_TIME in every player.

Source files
------------

// File: rtl/chess_clock_ctrl_if.sv
// Button, set and status bundle between the chess clock core and its neighbours.
// The master drives buttons and set data; the slave (the core) drives time and status.
interface chess_clock_ctrl_if #(
    parameter int NUM_PLAYERS = 2,
    parameter int TIME_W      = 12
);
    localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;

    logic                          tick;
    logic                          start_pause;
    logic                          move;
    logic                          set_mode;
    logic                          set_load;
    logic [PW-1:0]                 set_player;
    logic [TIME_W-1:0]             set_value;
    logic                          clear;
    logic [NUM_PLAYERS*TIME_W-1:0] time_flat;
    logic [PW-1:0]                 active_player;
    logic                          running;
    logic                          setting;
    logic                          flag;
    logic [PW-1:0]                 flag_player;

    modport master (
        output tick, start_pause, move, set_mode, set_load, set_player, set_value, clear,
        input  time_flat, active_player, running, setting, flag, flag_player
    );

    modport slave (
        input  tick, start_pause, move, set_mode, set_load, set_player, set_value, clear,
        output time_flat, active_player, running, setting, flag, flag_player
    );
endinterface

// File: rtl/chess_clock_ctrl.sv
// Multi-player chess clock core: per-player countdown, move switching with
// Fischer increment, pause, time setting and flag-fall detection.
module chess_clock_ctrl #(
    parameter int NUM_PLAYERS  = 2,
    parameter int TIME_W       = 12,
    parameter int DEFAULT_TIME = 300,
    parameter int INCREMENT    = 0
) (
    input  logic               clk,
    input  logic               reset,
    chess_clock_ctrl_if.slave  bus
);
    localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
    localparam logic [TIME_W-1:0] DEF_T  = TIME_W'(DEFAULT_TIME);
    localparam logic [TIME_W-1:0] MAX_T  = {TIME_W{1'b1}};
    localparam logic [PW-1:0]     LAST_P = PW'(NUM_PLAYERS - 1);
    // An increment wider than the counter simply pins the sum at full scale.
    localparam logic [TIME_W:0]   INC_W  = (INCREMENT > (2 ** TIME_W) - 1) ?
                                           {1'b0, MAX_T} : (TIME_W + 1)'(INCREMENT);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SET     = 3'd1,
        ST_RUN     = 3'd2,
        ST_PAUSE   = 3'd3,
        ST_FLAGGED = 3'd4
    } state_t;

    state_t            r_state;
    logic [TIME_W-1:0] r_time [NUM_PLAYERS];
    logic [PW-1:0]     r_active;
    logic [PW-1:0]     r_flag_player;
    logic              r_running;
    logic              r_setting;
    logic              r_flag;
    logic              r_sp_d;
    logic              r_mv_d;
    logic              r_ld_d;

    logic              w_sp_edge;
    logic              w_mv_edge;
    logic              w_ld_edge;
    logic              w_set_ok;
    logic [TIME_W-1:0] w_cur_time;
    logic [TIME_W-1:0] w_dec_time;
    logic [TIME_W:0]   w_sum;
    logic [TIME_W-1:0] w_inc_time;
    logic [PW-1:0]     w_next_p;

    // Edge detects, countdown, saturating increment and next-player selection.
    always_comb begin
        w_sp_edge  = bus.start_pause & ~r_sp_d;
        w_mv_edge  = bus.move        & ~r_mv_d;
        w_ld_edge  = bus.set_load    & ~r_ld_d;
        w_set_ok   = (int'(bus.set_player) < NUM_PLAYERS);
        w_cur_time = r_time[r_active];
        if (bus.tick && (w_cur_time != '0)) begin
            w_dec_time = w_cur_time - TIME_W'(1);
        end else begin
            w_dec_time = w_cur_time;
        end
        w_sum = {1'b0, w_dec_time} + INC_W;
        if (w_sum[TIME_W]) begin
            w_inc_time = MAX_T;
        end else begin
            w_inc_time = w_sum[TIME_W-1:0];
        end
        if (r_active == LAST_P) begin
            w_next_p = '0;
        end else begin
            w_next_p = r_active + PW'(1);
        end
    end

    // One-stage history of the level buttons for rising-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sp_d <= 1'b0;
            r_mv_d <= 1'b0;
            r_ld_d <= 1'b0;
        end else begin
            r_sp_d <= bus.start_pause;
            r_mv_d <= bus.move;
            r_ld_d <= bus.set_load;
        end
    end

    // Game state machine with its registered status outputs and time store.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_active      <= '0;
            r_flag_player <= '0;
            r_running     <= 1'b0;
            r_setting     <= 1'b0;
            r_flag        <= 1'b0;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                r_time[i] <= DEF_T;
            end
        end else if (bus.clear) begin
            r_state   <= ST_IDLE;
            r_active  <= '0;
            r_running <= 1'b0;
            r_setting <= 1'b0;
            r_flag    <= 1'b0;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                r_time[i] <= DEF_T;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.set_mode) begin
                        r_state   <= ST_SET;
                        r_setting <= 1'b1;
                    end else if (w_sp_edge) begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                        r_active  <= '0;
                    end else begin
                        r_state   <= ST_IDLE;
                    end
                end
                ST_SET: begin
                    if (w_ld_edge && w_set_ok) begin
                        r_time[bus.set_player] <= bus.set_value;
                    end
                    if (!bus.set_mode) begin
                        r_state   <= ST_IDLE;
                        r_setting <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_time[r_active] <= w_dec_time;
                    // A flag in this cycle swallows any move or pause seen with it.
                    if (w_dec_time == '0) begin
                        r_state       <= ST_FLAGGED;
                        r_running     <= 1'b0;
                        r_flag        <= 1'b1;
                        r_flag_player <= r_active;
                    end else begin
                        if (w_mv_edge) begin
                            r_time[r_active] <= w_inc_time;
                            r_active         <= w_next_p;
                        end
                        if (w_sp_edge) begin
                            r_state   <= ST_PAUSE;
                            r_running <= 1'b0;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (w_sp_edge) begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                    end
                end
                ST_FLAGGED: begin
                    r_state <= ST_FLAGGED;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_running <= 1'b0;
                    r_setting <= 1'b0;
                    r_flag    <= 1'b0;
                end
            endcase
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_PLAYERS; g++) begin : g_pack
            assign bus.time_flat[g*TIME_W +: TIME_W] = r_time[g];
        end
    endgenerate

    assign bus.active_player = r_active;
    assign bus.running       = r_running;
    assign bus.setting       = r_setting;
    assign bus.flag          = r_flag;
    assign bus.flag_player   = r_flag_player;
endmodule

// File: tb/tb_chess_clock_ctrl.sv
// Directed and random checks of the chess clock core against a behavioural game model.
module tb_chess_clock_ctrl;
    localparam int N     = 3;
    localparam int TW    = 12;
    localparam int DEF   = 300;
    localparam int INC   = 2;
    localparam int TMAX  = 4095;

    localparam int M_IDLE  = 0;
    localparam int M_SET   = 1;
    localparam int M_RUN   = 2;
    localparam int M_PAUSE = 3;
    localparam int M_FLAG  = 4;

    logic clk;
    logic reset;

    chess_clock_ctrl_if #(.NUM_PLAYERS(N), .TIME_W(TW)) bus ();

    chess_clock_ctrl #(
        .NUM_PLAYERS (N),
        .TIME_W      (TW),
        .DEFAULT_TIME(DEF),
        .INCREMENT   (INC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    int m_time [N];
    int m_active;
    int m_fp;
    int m_mode;
    bit p_sp, p_mv, p_ld;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_time[i] = DEF;
        m_active = 0;
        m_fp     = 0;
        m_mode   = M_IDLE;
        p_sp = 1'b0; p_mv = 1'b0; p_ld = 1'b0;
    endtask

    task automatic model_update(input bit tk, input bit spe, input bit mve, input bit sm,
                                input bit lde, input int spl, input int val, input bit clr);
        int t;
        if (clr) begin
            for (int i = 0; i < N; i++) m_time[i] = DEF;
            m_active = 0;
            m_mode   = M_IDLE;
        end else if (m_mode == M_IDLE) begin
            if (sm) m_mode = M_SET;
            else if (spe) begin
                m_mode   = M_RUN;
                m_active = 0;
            end
        end else if (m_mode == M_SET) begin
            if (lde && spl < N) m_time[spl] = val;
            if (!sm) m_mode = M_IDLE;
        end else if (m_mode == M_RUN) begin
            t = m_time[m_active];
            if (tk && t > 0) t = t - 1;
            m_time[m_active] = t;
            if (t == 0) begin
                m_mode = M_FLAG;
                m_fp   = m_active;
            end else begin
                if (mve) begin
                    m_time[m_active] = (t + INC > TMAX) ? TMAX : t + INC;
                    m_active = (m_active + 1) % N;
                end
                if (spe) m_mode = M_PAUSE;
            end
        end else if (m_mode == M_PAUSE) begin
            if (spe) m_mode = M_RUN;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < N; i++)
            chk($sformatf("time%0d", i), 32'(bus.time_flat[i*TW +: TW]), m_time[i]);
        chk("active_player", 32'(bus.active_player), m_active);
        chk("running", 32'(bus.running), (m_mode == M_RUN) ? 1 : 0);
        chk("setting", 32'(bus.setting), (m_mode == M_SET) ? 1 : 0);
        chk("flag", 32'(bus.flag), (m_mode == M_FLAG) ? 1 : 0);
        chk("flag_player", 32'(bus.flag_player), m_fp);
    endtask

    task automatic step(input bit tk, input bit sp, input bit mv, input bit sm, input bit ld,
                        input int spl, input int val, input bit clr);
        bus.tick        = tk;
        bus.start_pause = sp;
        bus.move        = mv;
        bus.set_mode    = sm;
        bus.set_load    = ld;
        bus.set_player  = 2'(spl);
        bus.set_value   = 12'(val);
        bus.clear       = clr;
        @(posedge clk);
        model_update(tk, sp & ~p_sp, mv & ~p_mv, sm, ld & ~p_ld, spl, val, clr);
        p_sp = sp; p_mv = mv; p_ld = ld;
        #1 check_all();
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic ticks(input int n);
        repeat (n) step(1, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic press_sp();
        step(0, 1, 0, 0, 0, 0, 0, 0); idle(1);
    endtask
    task automatic press_mv();
        step(0, 0, 1, 0, 0, 0, 0, 0); idle(1);
    endtask
    task automatic do_clear();
        step(0, 0, 0, 0, 0, 0, 0, 1); idle(1);
    endtask
    task automatic set_time(input int pl, input int val);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, pl, val, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        idle(1);
    endtask

    function automatic int tval(input int i);
        return int'(bus.time_flat[i*TW +: TW]);
    endfunction

    initial begin
        bit sm_lvl;
        int val;
        bus.tick = 1'b0; bus.start_pause = 1'b0; bus.move = 1'b0; bus.set_mode = 1'b0;
        bus.set_load = 1'b0; bus.set_player = '0; bus.set_value = '0; bus.clear = 1'b0;
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_all();
        reset = 1'b0;

        // Start and three ticks.
        press_sp();
        ticks(3);
        chk("tp1_time0", 32'(tval(0)), 297);
        chk("tp1_time1", 32'(tval(1)), 300);
        chk("tp1_running", 32'(bus.running), 1);

        // Five ticks then a move with increment 2.
        do_clear();
        press_sp();
        ticks(5);
        press_mv();
        chk("tp2_time0", 32'(tval(0)), 297);
        chk("tp2_active", 32'(bus.active_player), 1);
        ticks(1);
        chk("tp2_time1", 32'(tval(1)), 299);

        // Set player 1 to 2 s and run it down to a flag.
        do_clear();
        set_time(1, 2);
        press_sp();
        press_mv();
        ticks(2);
        chk("tp3_flag", 32'(bus.flag), 1);
        chk("tp3_flag_player", 32'(bus.flag_player), 1);
        chk("tp3_time1", 32'(tval(1)), 0);
        ticks(3);
        press_mv();
        press_sp();
        chk("tp3_frozen_time0", 32'(tval(0)), 302);

        // Pause freezes time, resume keeps the active player.
        do_clear();
        press_sp();
        press_mv();
        press_sp();
        ticks(10);
        chk("tp4_pause_time1", 32'(tval(1)), 300);
        press_sp();
        chk("tp4_resume_active", 32'(bus.active_player), 1);

        // Tick and move together on the last second: flag wins.
        do_clear();
        set_time(0, 1);
        press_sp();
        step(1, 0, 1, 0, 0, 0, 0, 0);
        chk("tp5_flag_player", 32'(bus.flag_player), 0);
        chk("tp5_active", 32'(bus.active_player), 0);
        chk("tp5_time0", 32'(tval(0)), 0);
        idle(1);

        // Clear out of FLAGGED.
        do_clear();
        chk("tp6_clear_time2", 32'(tval(2)), DEF);
        chk("tp6_clear_flag", 32'(bus.flag), 0);

        // Player rotation across three players.
        press_sp();
        press_mv();
        chk("rot_1", 32'(bus.active_player), 1);
        press_mv();
        chk("rot_2", 32'(bus.active_player), 2);
        press_mv();
        chk("rot_0", 32'(bus.active_player), 0);

        // Asynchronous reset in the middle of a running game.
        ticks(2);
        reset = 1'b1;
        #2;
        model_reset();
        check_all();
        @(posedge clk);
        #1 reset = 1'b0;

        // Saturating increment, invalid set target, starting with zero time.
        set_time(0, TMAX);
        set_time(3, 7);
        press_sp();
        press_mv();
        chk("sat_time0", 32'(tval(0)), TMAX);
        do_clear();
        set_time(0, 0);
        press_sp();
        chk("zero_start_flag", 32'(bus.flag), 1);
        do_clear();

        // Random phase against the model.
        sm_lvl = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 19) == 0) sm_lvl = ~sm_lvl;
            val = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4094, 4095))
                                              : int'($urandom_range(0, 7));
            step($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 4) == 0, sm_lvl, $urandom_range(0, 3) == 0,
                 int'($urandom_range(0, 3)), val, $urandom_range(0, 59) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
